// File: rtl/hilo_mdu_sched_if.sv
// hilo_mdu_sched_if: EX-stage mult/div request and HI/LO writeback bundle
//   master: issue/op/rs_val/rt_val/hilo_rd/hilo_mt/flush out; busy/stall/HIWrite/LOWrite/HI_out/LO_out in
//   slave : the reverse, used by the scheduler
interface hilo_mdu_sched_if #(parameter int XLEN = 32);
  logic            issue;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            hilo_rd;
  logic            hilo_mt;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            HIWrite;
  logic            LOWrite;
  logic [XLEN-1:0] HI_out;
  logic [XLEN-1:0] LO_out;
  modport master (output issue, op, rs_val, rt_val, hilo_rd, hilo_mt, flush,
                  input busy, stall, HIWrite, LOWrite, HI_out, LO_out);
  modport slave (input issue, op, rs_val, rt_val, hilo_rd, hilo_mt, flush,
                 output busy, stall, HIWrite, LOWrite, HI_out, LO_out);
endinterface

// File: rtl/hilo_mdu_sched.sv
// hilo_mdu_sched: iterative MULT/MULTU/DIV/DIVU unit with HI/LO writeback and pipeline stall control
//   clk, CLR_n (async active-low reset), bus (slave side of hilo_mdu_sched_if)
module hilo_mdu_sched #(
  parameter int XLEN      = 32,
  parameter int ZERO_FAST = 1
) (
  input logic              clk,
  input logic              CLR_n,
  hilo_mdu_sched_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, RUN, FIX, WB} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            div_q, nq_q, nr_q;
  logic [XLEN-1:0] m_q, hi_q, lo_q;
  logic            sgn, dz, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   madd, sh;
  logic [XLEN+1:0] dif;
  logic [2*XLEN-1:0] run_d, fix_d;
  // A zero divisor keeps the dividend unsigned so HI returns rs_val untouched
  // and LO ends as all ones, whether or not the fast path is taken.
  assign sgn   = ~bus.op[0];
  assign dz    = bus.op[1] & (bus.rt_val == '0);
  assign sa    = sgn & bus.rs_val[XLEN-1] & ~dz;
  assign sb    = sgn & bus.rt_val[XLEN-1];
  assign a_mag = sa ? -bus.rs_val : bus.rs_val;
  assign b_mag = sb ? -bus.rt_val : bus.rt_val;
  // Multiply: {hi,lo} shifts right, multiplier bit in lo[0] gates the add.
  // Divide: {hi,lo} shifts left, a restoring trial subtract sets the quotient bit.
  assign madd  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign sh    = {hi_q, lo_q[XLEN-1]};
  assign dif   = {1'b0, sh} - {2'b0, m_q};
  assign run_d = div_q ? {dif[XLEN+1] ? sh[XLEN-1:0] : dif[XLEN-1:0], lo_q[XLEN-2:0], ~dif[XLEN+1]}
                       : {madd, lo_q[XLEN-1:1]};
  assign fix_d = div_q ? {nr_q ? -hi_q : hi_q, nq_q ? -lo_q : lo_q}
                       : (nq_q ? -{hi_q, lo_q} : {hi_q, lo_q});
  always_ff @(posedge clk or negedge CLR_n)
    if (!CLR_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.issue) begin
          div_q <= bus.op[1];
          nq_q  <= sa ^ sb;
          nr_q  <= sa;
          cnt_q <= '0;
          m_q   <= bus.op[1] ? b_mag : a_mag;
          if (ZERO_FAST != 0 && dz) begin
            hi_q    <= bus.rs_val;
            lo_q    <= '1;
            state_q <= WB;
          end else begin
            hi_q    <= '0;
            lo_q    <= bus.op[1] ? a_mag : b_mag;
            state_q <= RUN;
          end
        end
        RUN: begin
          {hi_q, lo_q} <= run_d;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_q <= FIX;
        end
        FIX: begin
          {hi_q, lo_q} <= fix_d;
          state_q      <= WB;
        end
        default: state_q <= IDLE;
      endcase
    end
  // In WB the HI/LO write lands before the ID read, so MFHI/MFLO need not wait.
  assign bus.busy    = state_q != IDLE;
  assign bus.stall   = bus.busy & (bus.issue | bus.hilo_mt | (bus.hilo_rd & state_q != WB));
  assign bus.HIWrite = state_q == WB;
  assign bus.LOWrite = state_q == WB;
  assign bus.HI_out  = hi_q;
  assign bus.LO_out  = lo_q;
endmodule

// File: tb/tb_hilo_mdu_sched.sv
// tb_hilo_mdu_sched: randomized and directed checks of hilo_mdu_sched against a countdown/arithmetic model
module tb_hilo_mdu_sched;
  logic clk = 1'b0;
  logic CLR_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int left = 0;
  logic [63:0] exp_res = '0;
  hilo_mdu_sched_if bus();
  hilo_mdu_sched dut (.clk(clk), .CLR_n(CLR_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (o[1] && b == 32'd0) return {a, 32'hFFFFFFFF};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return 64'(ua * ub);
      2'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: begin q = ua / ub; r = ua % ub; return {r[31:0], q[31:0]}; end
    endcase
  endfunction
  // Model: 'left' is the number of busy cycles remaining including the current one.
  always @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) left = 0;
    else if (bus.flush) left = 0;
    else if (left > 0) left = left - 1;
    else if (bus.issue) begin
      left = (bus.op[1] && bus.rt_val == 32'd0) ? 1 : 34;
      exp_res = ref_res(bus.op, bus.rs_val, bus.rt_val);
    end
  end
  always @(negedge clk) begin
    logic e_busy, e_wb, e_stall;
    if (!CLR_n) begin
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst stall", 64'(bus.stall), 64'd0);
      chk("rst strobes", {62'd0, bus.HIWrite, bus.LOWrite}, 64'd0);
      chk("rst hilo", {bus.HI_out, bus.LO_out}, 64'd0);
    end else begin
      e_busy  = left > 0;
      e_wb    = left == 1;
      e_stall = e_busy & (bus.issue | bus.hilo_mt | (bus.hilo_rd & ~e_wb));
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("stall", 64'(bus.stall), 64'(e_stall));
      chk("strobes", {62'd0, bus.HIWrite, bus.LOWrite}, e_wb ? 64'd3 : 64'd0);
      if (e_wb) chk("result", {bus.HI_out, bus.LO_out}, exp_res);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el, input string nm);
    int n;
    bus.issue = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    tick();
    bus.issue = 1'b0;
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (bus.HIWrite) break;
      tick();
      n++;
    end
    chk({nm, " lat"}, 64'(n), 64'(lat));
    chk({nm, " HI"}, 64'(bus.HI_out), 64'(eh));
    chk({nm, " LO"}, 64'(bus.LO_out), 64'(el));
    tick();
  endtask
  task automatic start_mult();
    bus.issue = 1'b1; bus.op = 2'd0; bus.rs_val = 32'd1234; bus.rt_val = 32'hFFFF0001;
    tick();
    bus.issue = 1'b0;
  endtask
  initial begin
    bus.issue = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.hilo_rd = 0; bus.hilo_mt = 0; bus.flush = 0;
    #1 CLR_n = 1'b0;
    #2 chk("reset now", {bus.HI_out, bus.LO_out}, 64'd0);
    tick(); tick();
    CLR_n = 1'b1;
    run_op(2'd0, 32'hFFFFFFFF, 32'd1, 34, 32'hFFFFFFFF, 32'hFFFFFFFF, "mult -1*1");
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    run_op(2'd3, 32'hFFFFFFF9, 32'd2, 34, 32'd1, 32'h7FFFFFFC, "divu");
    run_op(2'd3, 32'h12345678, 32'd0, 1, 32'h12345678, 32'hFFFFFFFF, "divu by 0");
    chk("dz busy after", 64'(bus.busy), 64'd0);
    run_op(2'd2, 32'h80000000, 32'd0, 1, 32'h80000000, 32'hFFFFFFFF, "div by 0");
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 34, 32'd0, 32'h80000000, "div ovf");
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'd1, "multu max");
    // hilo_rd held from cycle 10 until the stall drops
    start_mult();
    for (int c = 1; c <= 35; c++) begin
      bus.hilo_rd = (c >= 10 && c <= 34);
      @(negedge clk);
      if (c >= 10) chk($sformatf("rd stall c%0d", c), 64'(bus.stall), 64'(c <= 33));
      tick();
    end
    bus.hilo_rd = 0;
    // second issue raised in cycle 5 is held and accepted at the end of cycle 35
    start_mult();
    for (int c = 1; c <= 36; c++) begin
      if (c == 5) begin bus.issue = 1; bus.op = 2'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7; end
      if (c == 36) bus.issue = 0;
      @(negedge clk);
      if (c >= 33) chk($sformatf("held busy c%0d", c), 64'(bus.busy), 64'(c != 35));
      tick();
    end
    repeat (36) tick();
    // flush mid-RUN
    start_mult();
    for (int c = 1; c <= 40; c++) begin
      bus.flush = (c == 20);
      @(negedge clk);
      if (c == 21) chk("flush idle", 64'(bus.busy), 64'd0);
      tick();
    end
    // flush and issue together in IDLE: issue dropped
    bus.flush = 1; bus.issue = 1; bus.op = 2'd1;
    tick();
    bus.flush = 0; bus.issue = 0;
    @(negedge clk);
    chk("flush+issue", 64'(bus.busy), 64'd0);
    tick();
    // flush during WB keeps that cycle's strobes
    start_mult();
    for (int c = 1; c <= 35; c++) begin
      bus.flush = (c == 34);
      @(negedge clk);
      if (c == 34) chk("wb flush strobe", 64'(bus.HIWrite), 64'd1);
      tick();
    end
    bus.flush = 0;
    // async reset mid-RUN
    start_mult();
    repeat (14) tick();
    #2 CLR_n = 1'b0;
    #1 chk("async rst", {29'd0, bus.busy, bus.HIWrite, bus.LOWrite, bus.HI_out}, 64'd0);
    tick(); tick();
    CLR_n = 1'b1;
    repeat (40) tick();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (!(bus.issue && bus.busy)) begin
        bus.issue  = $urandom_range(0, 5) == 0;
        bus.op     = 2'($urandom_range(0, 3));
        bus.rs_val = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
        case ($urandom_range(0, 7))
          0: bus.rt_val = 32'd0;
          1: bus.rt_val = 32'hFFFFFFFF;
          2: bus.rt_val = 32'($urandom_range(1, 9));
          default: bus.rt_val = $urandom;
        endcase
      end
      bus.flush   = $urandom_range(0, 59) == 0;
      bus.hilo_rd = $urandom_range(0, 3) == 0;
      bus.hilo_mt = $urandom_range(0, 5) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
